// File: rtl/bitboard_scanner.sv
// Bitboard scanner: accepts a WIDTH-bit square mask and emits the index of each
// set bit, lowest first, over a valid/ready handshake.
module bitboard_scanner #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_mask,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             done,
    output logic [IDX_W:0]   count
);

    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] lowest;
    logic [WIDTH-1:0] rest;
    logic [WIDTH-1:0] onehot;
    logic [IDX_W-1:0] index_enc;
    logic             handover;

    // Lowest remaining set bit, and the mask with that bit cleared.
    assign lowest = remain_q & (~remain_q + WIDTH'(1));
    assign rest   = remain_q & (remain_q - WIDTH'(1));

    assign out_valid  = (state_q == SCAN) && (remain_q != '0);
    assign out_last   = out_valid && (rest == '0);
    assign onehot     = out_valid ? lowest : '0;
    assign handover   = out_valid && out_ready;
    assign load_ready = (state_q == IDLE) && !abort;

    // One-hot to binary: each index bit is the OR of all squares whose number has that bit set.
    always_comb begin
        index_enc = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (onehot[i]) begin
                index_enc = index_enc | IDX_W'(i);
            end
        end
    end

    assign out_index = index_enc;
    assign done      = done_q;
    assign count     = count_q;

    // State register and scan datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            remain_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    // Next state; abort overrides load, handover and completion alike.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        count_d  = count_q;
        done_d   = 1'b0;

        if (abort) begin
            state_d  = IDLE;
            remain_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        remain_d = load_mask;
                        count_d  = '0;
                        state_d  = SCAN;
                    end
                end
                SCAN: begin
                    if (remain_q == '0) begin
                        // Empty mask: finish immediately without emitting.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (handover) begin
                        remain_d = rest;
                        count_d  = count_q + CNT_W'(1);
                        if (rest == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    remain_d = '0;
                end
            endcase
        end
    end

endmodule
